sync_down_counter: RTL and testbench
====================================

Name: sync_down_counter

Overview:
- Parameterised synchronous binary down counter. Companion to the 3-bit synchronous up counter; default WIDTH=3 counts 7,6,…,0.
- Built from per-bit toggle cells: bit i toggles when the count is enabled and all lower bits are 0 (borrow chain).
- Adds parallel load, three terminal-count policies (wrap, reload, one-shot), and cascade outputs so instances can be chained into wider timers.

Parameters:
- WIDTH, 3: counter width in bits (>=2).
- MODE, 0: terminal policy. 0 = WRAP (0 -> 2^WIDTH-1); 1 = RELOAD (0 -> last loaded value); 2 = ONESHOT (stop at 0 until next load).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  count enable; also the cascade borrow-in from a lower stage.
- load  in  1  parallel-load strobe.
- d  in  WIDTH  load value.
- Q  out  WIDTH  current count (registered).
- zero  out  1  combinational, Q==0.
- borrow  out  1  combinational, en & zero & counting-allowed; drives the next stage's en.
- tc  out  1  registered one-cycle pulse: the cycle after Q decremented from 1 to 0.
- busy  out  1  registered; 0 only in ONESHOT HALT state.

Behaviour:
- Reset, rst=0 sampled at rising edge: Q=0, reload register=all-ones, tc=0, state=RUN (busy=1). Exception: MODE=2 resets to HALT (busy=0). Reset overrides load and en in the same cycle.
- Priority per edge: reset > load > en > hold.
- load=1: Q<=d, reload register<=d, state<=RUN, tc<=0. en is ignored that cycle, so there is no decrement.
- en=1, no load, state RUN:
  - Q!=0: Q<=Q-1. Bit i toggles iff en & (Q[i-1:0]==0); bit 0 always toggles.
  - Q==0, MODE0: Q<=2^WIDTH-1.
  - Q==0, MODE1: Q<=reload register. A reload value of 0 holds Q at 0 with borrow asserted every enabled cycle.
  - Q==0, MODE2: Q holds 0, state<=HALT.
- State HALT (MODE2 only): Q holds, en ignored, borrow=0, busy=0. Exits only via load or reset.
- en=0: Q, state and reload register hold.
- tc<=1 only when the edge performs the 1->0 decrement; otherwise 0. Loading d=0 does not raise tc.
- borrow:
  - MODE0/1: en & zero.
  - MODE2: en & zero & (state==RUN). It is the pulse that moves the FSM into HALT.
- Latency: Q reflects load or decrement one cycle after the sampling edge. zero and borrow follow Q combinationally.
- Cascade: a stage's borrow feeds the next stage's en. A low stage at 0 with en=1 wraps/reloads while the high stage decrements in the same edge.
- Mid-count reset: Q returns to 0 on the next edge. No decrement is applied that edge.

Decomposition:
- Shared package sync_counter_pkg holds the MODE constants MODE_WRAP=0, MODE_RELOAD=1, MODE_ONESHOT=2 and the FSM encoding ST_RUN=1'b1, ST_HALT=1'b0.
- Sub-module tff_load_cell: one bit. Inputs clk, rst, load, d_bit, t; output q. Priority reset > load > toggle.
- The top level instantiates WIDTH cells. It generates the borrow-chain toggle terms, the terminal-policy override (forced load of all-ones or the reload value at zero), the reload register, the FSM, and tc.

Test Plan:
- Reset/free run, MODE0 WIDTH3: rst=0 for 2 edges, then rst=1, en=1 -> Q sequence 0,7,6,5,4,3,2,1,0,7; tc high exactly one cycle after Q becomes 0 from 1; borrow high while Q==0.
- Load priority, MODE0: at Q=5 drive load=1, d=2, en=1 -> next Q=2, not 1; following edges 1,0,7; tc pulses once.
- Reload, MODE1: load d=3, en=1 -> Q 3,2,1,0,3,2; after rst=0 (reload reg = 7) from Q=0 with en -> 7.
- One-shot, MODE2: after reset busy=0, Q=0, en ignored; load d=2, en=1 -> Q 2,1,0,0,0; busy drops the edge after Q==0 with en; borrow single cycle; reload d=1 -> busy=1, Q 1,0.
- Enable/hold and reset mid-count: en toggling 1,0,1 at Q=6 -> 5,5,4; rst=0 asserted with load=1, d=4 -> Q=0.
- Cascade: two WIDTH3 MODE0 instances, low.borrow->high.en, both reset, en=1 -> combined 6-bit value 0,63,62,…; check wrap of low from 0 to 7 coincides with high decrement over 70 cycles.

Source files
------------

// File: rtl/sync_counter_pkg.sv
// Shared constants for the synchronous counter family: terminal-count policies
// and the one-shot run/halt state encoding.
package sync_counter_pkg;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_RELOAD  = 1;
    localparam int MODE_ONESHOT = 2;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tff_load_cell.sv
// One counter bit: a toggle flip-flop with synchronous parallel load.
// Priority on each rising edge: reset > load > toggle.
module tff_load_cell (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d_bit,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (load) begin
            q <= d_bit;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Parameterised synchronous down counter built from toggle cells, with parallel
// load, wrap/reload/one-shot terminal policies and cascade (borrow) outputs.
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MODE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             borrow,
    output logic             tc,
    output logic             busy
);

    state_t           state_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_reg;

    logic [WIDTH-1:0] low_zero;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_d;
    logic             run;
    logic             step;
    logic             terminal;
    logic             cell_load;

    // Counting is only blocked in the one-shot HALT state.
    assign run      = (MODE != MODE_ONESHOT) || (state_reg == ST_RUN);
    assign step     = en & run;
    assign zero     = (Q == '0);
    assign borrow   = step & zero;
    assign busy     = (state_reg == ST_RUN);
    assign tc       = tc_reg;

    // At zero the wrap/reload policies force a load; one-shot simply holds.
    assign terminal  = step & zero & (MODE != MODE_ONESHOT);
    assign cell_load = load | terminal;
    assign cell_d    = load ? d : ((MODE == MODE_RELOAD) ? reload_reg : '1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign low_zero[gi] = 1'b1;
            end else begin : g_upper
                assign low_zero[gi] = (Q[gi-1:0] == '0);
            end

            assign toggle[gi] = step & ~zero & low_zero[gi];

            tff_load_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .load  (cell_load),
                .d_bit (cell_d[gi]),
                .t     (toggle[gi]),
                .q     (Q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= (MODE == MODE_ONESHOT) ? ST_HALT : ST_RUN;
            reload_reg <= '1;
            tc_reg     <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (load) begin
                reload_reg <= d;
                state_reg  <= ST_RUN;
            end else if (step) begin
                if (Q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                    tc_reg <= 1'b1;
                end
                if (zero && (MODE == MODE_ONESHOT)) begin
                    state_reg <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: vector table, directed mode sequences, randomized
// run against a behavioural model for all three modes, and a two-stage cascade.
module tb_sync_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       en;
    logic [2:0] d;

    logic [2:0] q_o      [3];
    logic       zero_o   [3];
    logic       borrow_o [3];
    logic       tc_o     [3];
    logic       busy_o   [3];

    logic       rst_c;
    logic       en_c;
    logic [2:0] q_lo, q_hi;
    logic       z_lo, z_hi, b_lo, b_hi, tc_lo, tc_hi, busy_lo, busy_hi;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state, one per mode.
    int mq    [3];
    int mrel  [3];
    int mhalt [3];
    int mtc   [3];
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sync_down_counter #(.WIDTH(3), .MODE(gi)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .load   (load),
            .d      (d),
            .Q      (q_o[gi]),
            .zero   (zero_o[gi]),
            .borrow (borrow_o[gi]),
            .tc     (tc_o[gi]),
            .busy   (busy_o[gi])
        );
    end

    sync_down_counter #(.WIDTH(3), .MODE(0)) u_lo (
        .clk(clk), .rst(rst_c), .en(en_c), .load(1'b0), .d(3'd0),
        .Q(q_lo), .zero(z_lo), .borrow(b_lo), .tc(tc_lo), .busy(busy_lo)
    );

    sync_down_counter #(.WIDTH(3), .MODE(0)) u_hi (
        .clk(clk), .rst(rst_c), .en(b_lo), .load(1'b0), .d(3'd0),
        .Q(q_hi), .zero(z_hi), .borrow(b_hi), .tc(tc_hi), .busy(busy_hi)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input int dv, input logic e);
        for (int m = 0; m < 3; m++) begin
            mtc[m] = 0;
            if (!r) begin
                mq[m]    = 0;
                mrel[m]  = 7;
                mhalt[m] = (m == 2) ? 1 : 0;
            end else if (l) begin
                mq[m]    = dv;
                mrel[m]  = dv;
                mhalt[m] = 0;
            end else if (e && !mhalt[m]) begin
                if (mq[m] == 1) mtc[m] = 1;
                if (mq[m] > 0) mq[m] = mq[m] - 1;
                else if (m == 0) mq[m] = 7;
                else if (m == 1) mq[m] = mrel[m];
                else mhalt[m] = 1;
            end
        end
        if (!r) model_ok = 1'b1;
    endtask

    // Drive one cycle, check combinational outputs before the edge and
    // registered outputs just after it.
    task automatic apply(input logic r, input logic l, input logic [2:0] dv, input logic e);
        rst = r; load = l; d = dv; en = e;
        #1;
        if (model_ok) begin
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("m%0d_zero q=%0d", m, mq[m]), zero_o[m], (mq[m] == 0) ? 1 : 0);
                chk($sformatf("m%0d_borrow q=%0d en=%0d", m, mq[m], e), borrow_o[m],
                    (e && mq[m] == 0 && !mhalt[m]) ? 1 : 0);
            end
        end
        @(posedge clk);
        model_step(r, l, int'(dv), e);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d_q", m), q_o[m], mq[m]);
            chk($sformatf("m%0d_tc", m), tc_o[m], mtc[m]);
            chk($sformatf("m%0d_busy", m), busy_o[m], mhalt[m] ? 0 : 1);
        end
    endtask

    typedef struct {
        logic       r;
        logic       l;
        logic [2:0] d;
        logic       e;
        logic [2:0] q;
        logic       tc;
    } vec_t;

    vec_t tbl[$];
    int   exp1[5] = '{2, 1, 0, 3, 2};

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; d = 3'd0;
        rst_c = 1'b0; en_c = 1'b0;

        // MODE0 expectations: reset, free run, load priority, enable hold, reset over load.
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0});
        for (int v = 7; v >= 1; v--) tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'(v), 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].l, tbl[i].d, tbl[i].e);
            chk($sformatf("tbl%0d_q", i), q_o[0], tbl[i].q);
            chk($sformatf("tbl%0d_tc", i), tc_o[0], tbl[i].tc);
        end

        // Reload policy: load 3 then count, then reset restores reload of all-ones.
        apply(1'b0, 1'b0, 3'd0, 1'b0);
        apply(1'b1, 1'b1, 3'd3, 1'b1);
        chk("reload_load_q", q_o[1], 3);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 3'd0, 1'b1);
            chk($sformatf("reload_seq%0d", i), q_o[1], exp1[i]);
        end
        apply(1'b0, 1'b0, 3'd0, 1'b1);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        chk("reload_after_rst", q_o[1], 7);

        // One-shot: halted after reset, runs after load, halts at zero.
        apply(1'b0, 1'b0, 3'd0, 1'b0);
        chk("os_rst_busy", busy_o[2], 0);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        chk("os_halt_q", q_o[2], 0);
        chk("os_halt_busy", busy_o[2], 0);
        apply(1'b1, 1'b1, 3'd2, 1'b1);
        chk("os_load_q", q_o[2], 2);
        chk("os_load_busy", busy_o[2], 1);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        chk("os_zero_q", q_o[2], 0);
        chk("os_zero_tc", tc_o[2], 1);
        chk("os_zero_busy", busy_o[2], 1);
        en = 1'b1; #1;
        chk("os_borrow_pulse", borrow_o[2], 1);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        chk("os_halted_busy", busy_o[2], 0);
        chk("os_halted_q", q_o[2], 0);
        en = 1'b1; #1;
        chk("os_borrow_off", borrow_o[2], 0);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        apply(1'b1, 1'b1, 3'd1, 1'b0);
        chk("os_reload_busy", busy_o[2], 1);
        apply(1'b1, 1'b0, 3'd0, 1'b1);
        chk("os_reload_q", q_o[2], 0);

        // Randomized run, all modes against the model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 50) != 0, ($urandom % 8) == 0,
                  3'($urandom_range(0, 7)), ($urandom % 4) != 0);
        end

        // Cascade: two 3-bit stages form a 6-bit down counter.
        rst_c = 1'b0; en_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("casc_rst", {q_hi, q_lo}, 0);
        rst_c = 1'b1; en_c = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("casc_k%0d", k), {q_hi, q_lo}, (64 - (k % 64)) % 64);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
